// File: rtl/robot_life_if.sv
// robot_life_if: signal bundle between the game-flow controller and the
// rest of the robot datapath (keyboard, collision, movement block, HUD).
//
//   start      controller in : start button level, debounced/synchronised
//   key_opr    controller in : raw keyboard opcode {up, down, left, right}
//   hit        controller in : collision level, sampled every cycle
//   move_opr   controller out: sanitised, registered opcode to movement block
//   alive      controller out: robot visible and movable
//   invuln     controller out: grace window active, hits ignored
//   respawn    controller out: one-cycle pulse, reload start position
//   lives      controller out: remaining lives
//   game_over  controller out: game over screen
//   state      controller out: IDLE=0 PLAY=1 DEAD=2 GRACE=3 OVER=4
//
// master: the side that drives the controls and observes the outputs.
// slave : the controller itself.
interface robot_life_if;
    logic       start;
    logic [3:0] key_opr;
    logic       hit;
    logic [3:0] move_opr;
    logic       alive;
    logic       invuln;
    logic       respawn;
    logic [2:0] lives;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output start, key_opr, hit,
        input  move_opr, alive, invuln, respawn, lives, game_over, state
    );

    modport slave (
        input  start, key_opr, hit,
        output move_opr, alive, invuln, respawn, lives, game_over, state
    );
endinterface

// File: rtl/robot_life_ctrl.sv
// robot_life_ctrl: game-flow controller for the player robot.
// Sequences IDLE -> PLAY -> DEAD -> (GRACE) -> PLAY ... -> OVER, owns the
// life counter, gates/sanitises the keyboard opcode and issues the
// one-cycle respawn pulse that reloads the robot start position.
//
// Ports:
//   clk_22  sole clock, all state on rising edge
//   rst     asynchronous active-low reset
//   bus     robot_life_if.slave (start/key_opr/hit in; move_opr, alive,
//           invuln, respawn, lives, game_over, state out)
//
// Parameters:
//   LIVES          lives granted at game start (1..7)
//   RESPAWN_TICKS  cycles spent in DEAD (2..255)
//   GRACE_TICKS    cycles spent in GRACE (2..255)
//
// Build option: define ROBOT_GRACE_EN to include the post-respawn GRACE
// state. Without it DEAD returns straight to PLAY, invuln is tied low and
// encoding 3 is handled like any other illegal encoding.
module robot_life_ctrl #(
    parameter int LIVES         = 3,
    parameter int RESPAWN_TICKS = 100,
    parameter int GRACE_TICKS   = 64
) (
    input  logic        clk_22,
    input  logic        rst,
    robot_life_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        DEAD  = 3'd2,
        GRACE = 3'd3,
        OVER  = 3'd4
    } state_t;

    // Parameter range checks at elaboration time.
    if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
        $error("robot_life_ctrl: LIVES out of range 1..7");
    end
    if (RESPAWN_TICKS < 2 || RESPAWN_TICKS > 255) begin : g_bad_respawn
        $error("robot_life_ctrl: RESPAWN_TICKS out of range 2..255");
    end
    if (GRACE_TICKS < 2 || GRACE_TICKS > 255) begin : g_bad_grace
        $error("robot_life_ctrl: GRACE_TICKS out of range 2..255");
    end

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] DEAD_LAST  = 8'(RESPAWN_TICKS - 1);
`ifdef ROBOT_GRACE_EN
    localparam logic [7:0] GRACE_LAST = 8'(GRACE_TICKS - 1);
`endif

    state_t     state_r, state_nx;
    logic [7:0] cnt_r, cnt_nx;
    logic [2:0] lives_r, lives_nx;
    logic [3:0] move_r, move_nx;
    logic       respawn_r, respawn_nx;
    logic       start_q;

    logic       start_rise;
    logic [3:0] key_clean;
    logic       move_en;

    // Only the rising edge of start counts, so a held button never
    // restarts a game that has just ended.
    assign start_rise = bus.start & ~start_q;

    // Opposing directions cancel each other; the rest pass through.
    always_comb begin
        key_clean = bus.key_opr;
        if (bus.key_opr[3] & bus.key_opr[2]) key_clean[3:2] = 2'b00;
        if (bus.key_opr[1] & bus.key_opr[0]) key_clean[1:0] = 2'b00;
    end

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            lives_r   <= 3'd0;
            move_r    <= 4'd0;
            respawn_r <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_r   <= state_nx;
            cnt_r     <= cnt_nx;
            lives_r   <= lives_nx;
            move_r    <= move_nx;
            respawn_r <= respawn_nx;
            start_q   <= bus.start;
        end
    end

    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        lives_nx   = lives_r;
        respawn_nx = 1'b0;

        case (state_r)
            IDLE, OVER: begin
                if (start_rise) begin
                    state_nx   = PLAY;
                    lives_nx   = LIVES_INIT;
                    cnt_nx     = 8'd0;
                    respawn_nx = 1'b1;
                end
            end

            PLAY: begin
                // hit has priority; start_rise is never looked at here.
                if (bus.hit) begin
                    if (lives_r <= 3'd1) begin
                        state_nx = OVER;
                        lives_nx = 3'd0;
                    end else begin
                        state_nx = DEAD;
                        lives_nx = lives_r - 3'd1;
                        cnt_nx   = 8'd0;
                    end
                end
            end

            DEAD: begin
                cnt_nx = cnt_r + 8'd1;
                if (cnt_r == DEAD_LAST) begin
`ifdef ROBOT_GRACE_EN
                    state_nx = GRACE;
`else
                    state_nx = PLAY;
`endif
                    cnt_nx     = 8'd0;
                    respawn_nx = 1'b1;
                end
            end

`ifdef ROBOT_GRACE_EN
            GRACE: begin
                cnt_nx = cnt_r + 8'd1;
                if (cnt_r == GRACE_LAST) begin
                    state_nx = PLAY;
                    cnt_nx   = 8'd0;
                end
            end
`endif

            default: begin
                // Unreachable encodings: recover to a clean IDLE.
                state_nx = IDLE;
                cnt_nx   = 8'd0;
                lives_nx = 3'd0;
            end
        endcase
    end

    // The opcode is gated by where the FSM is going, so it is zero in the
    // very first DEAD cycle and live in the first PLAY/GRACE cycle.
`ifdef ROBOT_GRACE_EN
    assign move_en = (state_nx == PLAY) || (state_nx == GRACE);
`else
    assign move_en = (state_nx == PLAY);
`endif
    assign move_nx = move_en ? key_clean : 4'b0000;

    assign bus.move_opr  = move_r;
    assign bus.respawn   = respawn_r;
    assign bus.lives     = lives_r;
    assign bus.state     = state_r;
    assign bus.game_over = (state_r == OVER);
`ifdef ROBOT_GRACE_EN
    assign bus.alive     = (state_r == PLAY) || (state_r == GRACE);
    assign bus.invuln    = (state_r == GRACE);
`else
    assign bus.alive     = (state_r == PLAY);
    assign bus.invuln    = 1'b0;
`endif

endmodule
